ram_readback_ctrl: RTL
======================

RAM_READBACK_CTRL -- requirements
Module: ram_readback_ctrl

Interface
REQ-001 The block SHALL have parameter RAM_DATA_WIDTH, default 32, meaning the width of a RAM word.
REQ-002 The block SHALL have parameter RAM_ADDR_WIDTH, default 16, meaning the width of a RAM word address.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-low (0 = in reset)
- start  in  1  one-cycle request to begin a readback, sampled in IDLE only
- start_addr  in  RAM_ADDR_WIDTH  first word address, sampled with start
- word_count  in  RAM_ADDR_WIDTH  number of words to read, sampled with start
- abort  in  1  terminate the current readback
- ram_external_control_enable  out  1  claims the RAM external port
- external_ram_enable  out  1  RAM enable
- external_ram_read_enable  out  1  RAM read strobe
- external_ram_write_enable  out  1  tied 0
- external_ram_addr  out  RAM_ADDR_WIDTH  read address
- external_ram_read_data  in  RAM_DATA_WIDTH  RAM read data
- dout  out  RAM_DATA_WIDTH  streamed word
- dout_addr  out  RAM_ADDR_WIDTH  address of dout
- dout_valid  out  1  dout holds a valid word
- dout_ready  in  1  sink accepts the word
- busy  out  1  readback in progress
- done  out  1  one-cycle pulse on normal completion

Function
REQ-004 The RAM read latency SHALL be exactly 1 cycle: data for the address presented with read_enable=1 at edge N is valid on external_ram_read_data after edge N+1.
REQ-005 The FSM SHALL have the states IDLE, ISSUE, CAPTURE, HOLD and DONE.
REQ-006 In IDLE with start=1 and word_count!=0, the block SHALL latch start_addr into addr and word_count into remaining, then go to ISSUE.
REQ-007 In IDLE with start=1 and word_count=0, the block SHALL go to DONE and perform no RAM access.
REQ-008 In ISSUE, the block SHALL drive read_enable=1 and external_ram_addr=addr, then go to CAPTURE.
REQ-009 In CAPTURE, the block SHALL register external_ram_read_data into dout and addr into dout_addr, set dout_valid=1, then go to HOLD.
REQ-010 In HOLD, dout, dout_addr and dout_valid SHALL stay stable until dout_ready=1.
REQ-011 On the handshake (dout_valid and dout_ready at the same edge), the block SHALL clear dout_valid, increment addr modulo 2^RAM_ADDR_WIDTH (0xFFFF wraps to 0x0000), and decrement remaining.
REQ-012 After the handshake, the block SHALL go to ISSUE if the decremented remaining is non-zero, otherwise to DONE.
REQ-013 The maximum throughput SHALL be one word per 3 cycles when dout_ready is held 1.
REQ-014 In DONE, the block SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-015 ram_external_control_enable and external_ram_enable SHALL be 1 in ISSUE, CAPTURE and HOLD, and 0 in IDLE and DONE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 external_ram_write_enable SHALL be 0 at all times.
REQ-018 external_ram_read_enable SHALL be 1 only in ISSUE.
REQ-019 start asserted while not in IDLE SHALL be ignored, with no effect on the current transfer.
REQ-020 abort=1 in any non-IDLE state SHALL move the FSM to IDLE at the next edge, clear dout_valid and suppress done; abort SHALL take priority over a same-cycle handshake, and that word SHALL be counted as not delivered.
REQ-021 abort in IDLE SHALL be ignored; start and abort asserted together in IDLE SHALL leave the block in IDLE.
REQ-022 A word_count of 2^RAM_ADDR_WIDTH-1 SHALL be supported without counter overflow.

Reset
REQ-023 While reset=0, the FSM SHALL be in IDLE and addr, remaining, dout and dout_addr SHALL be 0.
REQ-024 While reset=0, dout_valid, busy, done, ram_external_control_enable, external_ram_enable and external_ram_read_enable SHALL be 0.
REQ-025 Reset asserted mid-transfer SHALL release the RAM port immediately (asynchronously), and the interrupted readback SHALL NOT resume after reset deasserts.

Verification
REQ-026 RAM preloaded with words 1..6 at addresses 1..6; start, start_addr=1, word_count=6, dout_ready=1 -> dout sequence 1..6 with dout_addr 1..6, one done pulse, busy=0 afterwards, write_enable never 1.
REQ-027 start with word_count=0 -> done pulses 2 cycles after start, read_enable never asserted.
REQ-028 start_addr=0xFFFE, word_count=3 -> external_ram_addr sequence 0xFFFE, 0xFFFF, 0x0000.
REQ-029 dout_ready held 0 for 10 cycles in HOLD -> dout and dout_addr stable and no new read issued; dout_ready=1 -> transfer resumes with the next address.
REQ-030 abort asserted during word 3 of 6 -> IDLE next cycle, dout_valid=0, no done pulse; a new start is accepted afterwards.
REQ-031 reset driven to 0 during CAPTURE -> all outputs 0 without waiting for a clock edge; start pulsed during busy -> no change in the current transfer.

Source files
------------

// File: rtl/ram_readback_ctrl.sv
// ram_readback_ctrl: streams a block of words out of a RAM with 1-cycle read latency
// over a valid/ready port. Only one read is in flight at a time, so each word takes 3 cycles.
module ram_readback_ctrl #(
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [RAM_ADDR_WIDTH-1:0] start_addr,
    input  logic [RAM_ADDR_WIDTH-1:0] word_count,
    input  logic                      abort,
    output logic                      ram_external_control_enable,
    output logic                      external_ram_enable,
    output logic                      external_ram_read_enable,
    output logic                      external_ram_write_enable,
    output logic [RAM_ADDR_WIDTH-1:0] external_ram_addr,
    input  logic [RAM_DATA_WIDTH-1:0] external_ram_read_data,
    output logic [RAM_DATA_WIDTH-1:0] dout,
    output logic [RAM_ADDR_WIDTH-1:0] dout_addr,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      busy,
    output logic                      done
);
    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, HOLD, DONE} state_t;
    localparam logic [RAM_ADDR_WIDTH-1:0] ONE = RAM_ADDR_WIDTH'(1);
    state_t                    state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, remaining_q, dout_addr_q;
    logic [RAM_DATA_WIDTH-1:0] dout_q;
    logic                      dout_valid_q, port_q, read_q, busy_q, done_q;
    logic                      accept, handshake;
    assign accept    = state_q == IDLE && start && !abort && word_count != '0;
    assign handshake = state_q == HOLD && dout_valid_q && dout_ready && !abort;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (start && !abort) ? ((word_count == '0) ? DONE : ISSUE) : IDLE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = HOLD;
            HOLD:    state_d = !handshake ? HOLD : (remaining_q == ONE) ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
    end
    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            dout_q       <= '0;
            dout_addr_q  <= '0;
            dout_valid_q <= 1'b0;
            port_q       <= 1'b0;
            read_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_q       <= state_d inside {ISSUE, CAPTURE, HOLD};
            read_q       <= state_d == ISSUE;
            busy_q       <= state_d != IDLE;
            done_q       <= state_d == DONE;
            dout_valid_q <= state_d == HOLD;
            if (accept) begin
                addr_q      <= start_addr;
                remaining_q <= word_count;
            end
            if (handshake) begin
                addr_q      <= addr_q + ONE;
                remaining_q <= remaining_q - ONE;
            end
            if (state_q == CAPTURE && !abort) begin
                dout_q      <= external_ram_read_data;
                dout_addr_q <= addr_q;
            end
        end
    end
    assign ram_external_control_enable = port_q;
    assign external_ram_enable         = port_q;
    assign external_ram_read_enable    = read_q;
    assign external_ram_write_enable   = 1'b0;
    assign external_ram_addr           = addr_q;
    assign dout                        = dout_q;
    assign dout_addr                   = dout_addr_q;
    assign dout_valid                  = dout_valid_q;
    assign busy                        = busy_q;
    assign done                        = done_q;
endmodule
